// File: rtl/pr_softreg_ctrl.sv
// SoftReg control stage for the PageRank core: latches graph parameters, launches
// the core, ping-pongs the prefix-sum buffers and serves the blocking DONE_ALL read.
module pr_softreg_ctrl #(
  parameter logic [31:0] A_N_VERT           = 32'd0,
  parameter logic [31:0] A_N_INEDGES        = 32'd8,
  parameter logic [31:0] A_VADDR            = 32'd16,
  parameter logic [31:0] A_IEADDR           = 32'd24,
  parameter logic [31:0] A_WRITE_ADDR0      = 32'd32,
  parameter logic [31:0] A_WRITE_ADDR1      = 32'd40,
  parameter logic [31:0] A_DONE_READ_PARAMS = 32'd48,
  parameter logic [31:0] A_DONE_ALL         = 32'd56
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        softreg_req_valid,
  input  logic        softreg_req_isWrite,
  input  logic [31:0] softreg_req_addr,
  input  logic [63:0] softreg_req_data,
  output logic        softreg_resp_valid,
  output logic [63:0] softreg_resp_data,
  output logic [63:0] n_vert,
  output logic [63:0] n_inedges,
  output logic [63:0] vaddr,
  output logic [63:0] ieaddr,
  output logic [63:0] wr_base,
  output logic [63:0] rd_base,
  output logic        start,
  output logic        busy,
  input  logic        iter_done,
  input  logic        core_done,
  input  logic [63:0] result,
  output logic [31:0] iter_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] n_vert_q, n_vert_d, n_inedges_q, n_inedges_d;
  logic [63:0] vaddr_q, vaddr_d, ieaddr_q, ieaddr_d;
  logic [63:0] wa0_q, wa0_d, wa1_q, wa1_d, res_q, res_d;
  logic        sel_q, sel_d, done_q, done_d, pend_q, pend_d, start_q, start_d;
  logic [31:0] iter_q, iter_d;
  logic        resp_valid_q, resp_valid_d, defer_valid_q, defer_valid_d;
  logic [63:0] resp_data_q, resp_data_d, defer_data_q, defer_data_d;

  logic        is_wr, is_rd, core_fin, pend_fire, cfg_hit, new_rd;
  logic [63:0] new_data;

  assign is_wr     = softreg_req_valid && softreg_req_isWrite;
  assign is_rd     = softreg_req_valid && !softreg_req_isWrite;
  assign core_fin  = (state_q == RUN) && core_done;
  assign pend_fire = pend_q && core_fin;

  always_comb begin
    state_d       = state_q;
    n_vert_d      = n_vert_q;
    n_inedges_d   = n_inedges_q;
    vaddr_d       = vaddr_q;
    ieaddr_d      = ieaddr_q;
    wa0_d         = wa0_q;
    wa1_d         = wa1_q;
    res_d         = res_q;
    sel_d         = sel_q;
    done_d        = done_q;
    pend_d        = pend_q;
    iter_d        = iter_q;
    start_d       = 1'b0;
    resp_valid_d  = 1'b0;
    resp_data_d   = '0;
    defer_valid_d = 1'b0;
    defer_data_d  = '0;
    cfg_hit       = 1'b0;
    new_rd        = 1'b0;
    new_data      = '0;

    // Parameters are only writable outside RUN; a config write also leaves DONE.
    if (is_wr && state_q != RUN) begin
      cfg_hit = 1'b1;
      case (softreg_req_addr)
        A_N_VERT:      n_vert_d    = softreg_req_data;
        A_N_INEDGES:   n_inedges_d = softreg_req_data;
        A_VADDR:       vaddr_d     = softreg_req_data;
        A_IEADDR:      ieaddr_d    = softreg_req_data;
        A_WRITE_ADDR0: wa0_d       = softreg_req_data;
        A_WRITE_ADDR1: wa1_d       = softreg_req_data;
        default:       cfg_hit     = 1'b0;
      endcase
      if (cfg_hit) begin
        state_d = IDLE;
        done_d  = 1'b0;
      end else if (softreg_req_addr == A_DONE_READ_PARAMS && n_vert_q != 64'd0) begin
        state_d = RUN;
        start_d = 1'b1;
        sel_d   = 1'b0;
        iter_d  = '0;
        done_d  = 1'b0;
      end
    end

    if (state_q == RUN) begin
      if (iter_done) begin
        sel_d = ~sel_q;
        if (iter_q != 32'hFFFF_FFFF) iter_d = iter_q + 32'd1;
      end
      if (core_done) begin
        res_d   = result;
        done_d  = 1'b1;
        state_d = DONE;
      end
    end

    if (is_rd) begin
      new_rd = 1'b1;
      case (softreg_req_addr)
        A_N_VERT:      new_data = n_vert_q;
        A_N_INEDGES:   new_data = n_inedges_q;
        A_VADDR:       new_data = vaddr_q;
        A_IEADDR:      new_data = ieaddr_q;
        A_WRITE_ADDR0: new_data = wa0_q;
        A_WRITE_ADDR1: new_data = wa1_q;
        A_DONE_ALL: begin
          new_rd = 1'b0;
          if (!pend_q) begin
            if (done_q) begin
              new_rd   = 1'b1;
              new_data = res_q;
            end else if (core_fin) begin
              new_rd   = 1'b1;
              new_data = result;
            end else begin
              pend_d = 1'b1;
            end
          end
        end
        default:       new_data = '0;
      endcase
    end
    if (pend_fire) pend_d = 1'b0;

    // Completing DONE_ALL wins the response slot, then any deferred reply, then a new read.
    if (pend_fire) begin
      resp_valid_d  = 1'b1;
      resp_data_d   = result;
      defer_valid_d = new_rd;
      defer_data_d  = new_data;
    end else if (defer_valid_q) begin
      resp_valid_d  = 1'b1;
      resp_data_d   = defer_data_q;
      defer_valid_d = new_rd;
      defer_data_d  = new_data;
    end else if (new_rd) begin
      resp_valid_d  = 1'b1;
      resp_data_d   = new_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      n_vert_q      <= '0;
      n_inedges_q   <= '0;
      vaddr_q       <= '0;
      ieaddr_q      <= '0;
      wa0_q         <= '0;
      wa1_q         <= '0;
      res_q         <= '0;
      sel_q         <= 1'b0;
      done_q        <= 1'b0;
      pend_q        <= 1'b0;
      iter_q        <= '0;
      start_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      defer_valid_q <= 1'b0;
      defer_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      n_vert_q      <= n_vert_d;
      n_inedges_q   <= n_inedges_d;
      vaddr_q       <= vaddr_d;
      ieaddr_q      <= ieaddr_d;
      wa0_q         <= wa0_d;
      wa1_q         <= wa1_d;
      res_q         <= res_d;
      sel_q         <= sel_d;
      done_q        <= done_d;
      pend_q        <= pend_d;
      iter_q        <= iter_d;
      start_q       <= start_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      defer_valid_q <= defer_valid_d;
      defer_data_q  <= defer_data_d;
    end
  end

  assign softreg_resp_valid = resp_valid_q;
  assign softreg_resp_data  = resp_data_q;
  assign n_vert             = n_vert_q;
  assign n_inedges          = n_inedges_q;
  assign vaddr              = vaddr_q;
  assign ieaddr             = ieaddr_q;
  assign wr_base            = sel_q ? wa1_q : wa0_q;
  assign rd_base            = sel_q ? wa0_q : wa1_q;
  assign start              = start_q;
  assign busy               = (state_q == RUN);
  assign iter_count         = iter_q;

endmodule

// File: tb/tb_pr_softreg_ctrl.sv
// Scoreboard bench for pr_softreg_ctrl: a register-level reference model predicts
// outputs and read responses; a negedge monitor checks every response it sees.
module tb_pr_softreg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        softreg_req_valid, softreg_req_isWrite;
  logic [31:0] softreg_req_addr;
  logic [63:0] softreg_req_data;
  logic        softreg_resp_valid;
  logic [63:0] softreg_resp_data;
  logic [63:0] n_vert, n_inedges, vaddr, ieaddr, wr_base, rd_base;
  logic        start, busy, iter_done, core_done;
  logic [63:0] result;
  logic [31:0] iter_count;

  pr_softreg_ctrl dut (
    .clk(clk), .rst(rst),
    .softreg_req_valid(softreg_req_valid), .softreg_req_isWrite(softreg_req_isWrite),
    .softreg_req_addr(softreg_req_addr), .softreg_req_data(softreg_req_data),
    .softreg_resp_valid(softreg_resp_valid), .softreg_resp_data(softreg_resp_data),
    .n_vert(n_vert), .n_inedges(n_inedges), .vaddr(vaddr), .ieaddr(ieaddr),
    .wr_base(wr_base), .rd_base(rd_base), .start(start), .busy(busy),
    .iter_done(iter_done), .core_done(core_done), .result(result),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } exp_t;
  exp_t expQ[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: six parameter registers indexed by address/8.
  logic [63:0] mReg [6];
  bit          mRun, mDone, mPend, mSel, mStart;
  logic [31:0] mIter;
  logic [63:0] mRes;

  function automatic void chk64(string name, logic [63:0] act, logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endfunction

  function automatic int cfgIdx(logic [31:0] a);
    if (a <= 32'd40 && a[2:0] == 3'd0) return int'(a >> 3);
    return -1;
  endfunction

  function automatic bit slotTaken(int t);
    foreach (expQ[i]) if (expQ[i].cyc == t) return 1'b1;
    return 1'b0;
  endfunction

  // A reply wants the cycle after its request; if that cycle is already claimed it slides later.
  function automatic void schedule(int c, logic [63:0] d);
    exp_t e;
    int   t = c + 1;
    int   idx;
    while (slotTaken(t)) t++;
    e.cyc  = t;
    e.data = d;
    idx = expQ.size();
    for (int i = 0; i < expQ.size(); i++)
      if (expQ[i].cyc > t) begin idx = i; break; end
    expQ.insert(idx, e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL missing_resp at cycle %0d: got none expected data %0h at cycle %0d",
               cyc, expQ[0].data, expQ[0].cyc);
      void'(expQ.pop_front());
    end
    if (softreg_resp_valid) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_resp at cycle %0d: got data %0h expected no response",
                 cyc, softreg_resp_data);
      end else begin
        e = expQ.pop_front();
        chk64("resp_cycle", 64'(cyc), 64'(e.cyc));
        chk64("resp_data", softreg_resp_data, e.data);
      end
    end
  end

  task automatic checkOutput();
    chk64("n_vert", n_vert, mReg[0]);
    chk64("n_inedges", n_inedges, mReg[1]);
    chk64("vaddr", vaddr, mReg[2]);
    chk64("ieaddr", ieaddr, mReg[3]);
    chk64("wr_base", wr_base, mSel ? mReg[5] : mReg[4]);
    chk64("rd_base", rd_base, mSel ? mReg[4] : mReg[5]);
    chk64("start", 64'(start), 64'(mStart));
    chk64("busy", 64'(busy), 64'(mRun));
    chk64("iter_count", 64'(iter_count), 64'(mIter));
  endtask

  // One clock cycle of stimulus: check the outputs, drive the inputs, advance the model.
  task automatic applyStimulus(bit r, bit v, bit w, logic [31:0] a, logic [63:0] d,
                               bit it, bit cd, logic [63:0] res);
    int c;
    int idx;
    bit run0, pend0, fin, newStart;
    @(posedge clk);
    #1;
    checkOutput();
    rst                 = r;
    softreg_req_valid   = v;
    softreg_req_isWrite = w;
    softreg_req_addr    = a;
    softreg_req_data    = d;
    iter_done           = it;
    core_done           = cd;
    result              = res;
    c = cyc;
    if (r) begin
      foreach (mReg[i]) mReg[i] = '0;
      {mRun, mDone, mPend, mSel, mStart} = '0;
      mIter = '0;
      mRes  = '0;
      for (int i = expQ.size() - 1; i >= 0; i--)
        if (expQ[i].cyc > c) expQ.delete(i);
    end else begin
      run0 = mRun;
      pend0 = mPend;
      fin = mRun && cd;
      newStart = 1'b0;
      if (pend0 && fin) begin
        schedule(c, res);
        mPend = 1'b0;
      end
      if (v && !w) begin
        idx = cfgIdx(a);
        if (idx >= 0) schedule(c, mReg[idx]);
        else if (a == 32'd56) begin
          if (!pend0) begin
            if (mDone) schedule(c, mRes);
            else if (fin) schedule(c, res);
            else mPend = 1'b1;
          end
        end else schedule(c, 64'd0);
      end
      if (v && w && !run0) begin
        idx = cfgIdx(a);
        if (idx >= 0) begin
          mReg[idx] = d;
          mDone = 1'b0;
        end else if (a == 32'd48 && mReg[0] != 64'd0) begin
          mRun = 1'b1;
          newStart = 1'b1;
          mSel = 1'b0;
          mIter = '0;
          mDone = 1'b0;
        end
      end
      if (run0) begin
        if (it) begin
          mSel = ~mSel;
          if (mIter != 32'hFFFF_FFFF) mIter++;
        end
        if (cd) begin
          mRes = res;
          mDone = 1'b1;
          mRun = 1'b0;
        end
      end
      mStart = newStart;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(logic [31:0] a, logic [63:0] d);
    applyStimulus(0, 1, 1, a, d, 0, 0, 0);
  endtask

  task automatic rd(logic [31:0] a);
    applyStimulus(0, 1, 0, a, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] addrs [10] = '{0, 8, 16, 24, 32, 40, 48, 56, 4, 100};
    logic [31:0] a;
    logic [63:0] d;
    int k;
    rst = 1'b1;
    softreg_req_valid = 0; softreg_req_isWrite = 0; softreg_req_addr = 0;
    softreg_req_data = 0; iter_done = 0; core_done = 0; result = 0;
    repeat (2) @(posedge clk);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    $display("[TB] config and launch");
    wr(0, 10); wr(8, 47); wr(16, 0); wr(24, 160); wr(32, 1240); wr(40, 1360);
    rd(8); rd(40); rd(4);
    wr(48, 0);
    idle(3);

    $display("[TB] ping-pong");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
      idle(2);
    end

    $display("[TB] lock");
    wr(0, 99); rd(0); idle(2);

    $display("[TB] blocking DONE_ALL");
    rd(56);
    idle(49);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h1234);
    idle(2);
    rd(56);
    idle(2);

    $display("[TB] same-cycle completion");
    wr(48, 0);
    idle(2);
    applyStimulus(0, 1, 0, 56, 0, 0, 1, 64'd7);
    idle(3);

    $display("[TB] collision between DONE_ALL and config read");
    wr(48, 0);
    rd(56);
    idle(3);
    applyStimulus(0, 1, 0, 8, 0, 0, 1, 64'hABCD);
    rd(16); rd(24);
    idle(3);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0 && !mRun) begin
        wr(0, 64'($urandom_range(1, 20)));
        wr(48, 0);
      end
      k = $urandom_range(0, 9);
      a = addrs[$urandom_range(0, 9)];
      d = (a == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      applyStimulus(0, k < 5, k >= 3 && k < 5, a, d,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
                    {$urandom, $urandom});
    end
    idle(3);
    if (mRun) applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'd1);
    idle(3);

    $display("[TB] zero-vertex launch");
    wr(0, 0);
    wr(48, 0);
    idle(3);

    $display("[TB] reset mid-run with pending read");
    wr(0, 5); wr(32, 64'h100); wr(40, 64'h200);
    wr(48, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    rd(56);
    idle(3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h55);
    idle(5);

    chk64("queue_drained", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
